// File: rtl/trb_st2bus_if.sv
// rtl/trb_st2bus_if.sv - ST beat input and packed bus word output bundle for trb_st2bus
interface trb_st2bus_if #(
  parameter int ST    = 8,
  parameter int BUS_W = 512,
  parameter int CNT_W = 7
);
  logic [ST-1:0]    st_data;
  logic             st_valid;
  logic             st_sop;
  logic             st_eop;
  logic             st_ready;
  logic [BUS_W-1:0] bus_data;
  logic             bus_valid;
  logic [CNT_W-1:0] bus_bytes;
  logic             bus_last;
  logic             bus_ready;

  modport master (
    output st_data, st_valid, st_sop, st_eop, bus_ready,
    input  st_ready, bus_data, bus_valid, bus_bytes, bus_last
  );

  modport slave (
    input  st_data, st_valid, st_sop, st_eop, bus_ready,
    output st_ready, bus_data, bus_valid, bus_bytes, bus_last
  );
endinterface

// File: rtl/trb_st2bus.sv
// rtl/trb_st2bus.sv - packs an 8-bit ST decoded-bit stream into wide bus words (optional stats: TRB_ST2BUS_STAT_EN)
module trb_st2bus #(
  parameter int ST    = 8,
  parameter int BUS_W = 512,
  parameter int CNT_W = 7
) (
  input logic         clk,
  input logic         rst,
  trb_st2bus_if.slave io
`ifdef TRB_ST2BUS_STAT_EN
  ,
  output logic [15:0] pkt_cnt,
  output logic [15:0] drop_cnt
`endif
);
  localparam int               BPW       = BUS_W / ST;
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(BPW - 1);

  typedef enum logic {IDLE = 1'b0, PKT = 1'b1} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [BUS_W-1:0] acc;
  logic             pend;
  logic [CNT_W-1:0] pend_bytes;
  logic             pend_last;
  logic             side_vld;
  logic [ST-1:0]    side_data;
  logic             side_eop;
  logic [BUS_W-1:0] ob_data;
  logic             ob_valid;
  logic [CNT_W-1:0] ob_bytes;
  logic             ob_last;

  logic             st_ready_c;
  logic             accept;
  logic             drain;
  logic             obuf_free;
  logic             drop;
  logic             trunc;
  logic             done;
  logic [CNT_W-1:0] slot;
  logic [BUS_W-1:0] beat_word;
  logic [BUS_W-1:0] side_word;

  // Input side stalls only while a finished word waits for the output buffer.
  assign st_ready_c = !rst && !pend;
  assign accept     = io.st_valid && st_ready_c;
  assign drain      = ob_valid && io.bus_ready;
  assign obuf_free  = !ob_valid || io.bus_ready;
  assign drop       = accept && (state == IDLE) && !io.st_sop;
  assign trunc      = accept && (state == PKT) && io.st_sop && (cnt != '0);
  assign slot       = io.st_sop ? '0 : cnt;
  assign done       = accept && !drop && (io.st_eop || (slot == LAST_SLOT));
  assign side_word  = BUS_W'(side_data);

  assign io.st_ready  = st_ready_c;
  assign io.bus_data  = ob_data;
  assign io.bus_valid = ob_valid;
  assign io.bus_bytes = ob_bytes;
  assign io.bus_last  = ob_last;

  // Word with the incoming beat placed in its slot; a sop beat always starts from an empty word.
  always_comb begin
    beat_word = io.st_sop ? '0 : acc;
    for (int k = 0; k < BPW; k++) begin
      if (slot == CNT_W'(k)) beat_word[k*ST +: ST] = io.st_data;
    end
  end

  // Packing state machine: accumulator, pending word, side beat and output buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      acc        <= '0;
      pend       <= 1'b0;
      pend_bytes <= '0;
      pend_last  <= 1'b0;
      side_vld   <= 1'b0;
      side_data  <= '0;
      side_eop   <= 1'b0;
      ob_data    <= '0;
      ob_valid   <= 1'b0;
      ob_bytes   <= '0;
      ob_last    <= 1'b0;
    end else if (pend) begin
      if (obuf_free) begin
        ob_valid <= 1'b1;
        ob_data  <= acc;
        ob_bytes <= pend_bytes;
        ob_last  <= pend_last;
        if (side_vld) begin
          // The beat that truncated the previous packet now opens a fresh word.
          side_vld <= 1'b0;
          acc      <= side_word;
          if (side_eop) begin
            pend_bytes <= CNT_W'(1);
            pend_last  <= 1'b1;
            cnt        <= '0;
            state      <= IDLE;
          end else begin
            pend  <= 1'b0;
            cnt   <= CNT_W'(1);
            state <= PKT;
          end
        end else begin
          acc  <= '0;
          pend <= 1'b0;
        end
      end
    end else begin
      if (drain) ob_valid <= 1'b0;
      if (trunc) begin
        if (obuf_free) begin
          ob_valid <= 1'b1;
          ob_data  <= acc;
          ob_bytes <= cnt;
          ob_last  <= 1'b1;
          acc      <= beat_word;
          if (io.st_eop) begin
            pend       <= 1'b1;
            pend_bytes <= CNT_W'(1);
            pend_last  <= 1'b1;
            cnt        <= '0;
            state      <= IDLE;
          end else begin
            cnt   <= CNT_W'(1);
            state <= PKT;
          end
        end else begin
          pend       <= 1'b1;
          pend_bytes <= cnt;
          pend_last  <= 1'b1;
          side_vld   <= 1'b1;
          side_data  <= io.st_data;
          side_eop   <= io.st_eop;
        end
      end else if (done) begin
        cnt   <= '0;
        state <= io.st_eop ? IDLE : PKT;
        if (obuf_free) begin
          ob_valid <= 1'b1;
          ob_data  <= beat_word;
          ob_bytes <= slot + CNT_W'(1);
          ob_last  <= io.st_eop;
          acc      <= '0;
        end else begin
          acc        <= beat_word;
          pend       <= 1'b1;
          pend_bytes <= slot + CNT_W'(1);
          pend_last  <= io.st_eop;
        end
      end else if (accept && !drop) begin
        acc   <= beat_word;
        cnt   <= slot + CNT_W'(1);
        state <= PKT;
      end
    end
  end

`ifdef TRB_ST2BUS_STAT_EN
  // Saturating packet and drop counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (drain && ob_last && (pkt_cnt != 16'hFFFF)) pkt_cnt <= pkt_cnt + 16'd1;
      if ((drop || trunc) && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_trb_st2bus.sv
// tb/tb_trb_st2bus.sv - directed and randomized bench for trb_st2bus (stats checked when TRB_ST2BUS_STAT_EN is defined)
`timescale 1ns/1ps
module tb_trb_st2bus;
  localparam int ST    = 8;
  localparam int BUS_W = 512;
  localparam int CNT_W = 7;
  localparam int BPW   = BUS_W / ST;
  localparam int LIMIT = 3000;

  logic clk = 1'b0;
  logic rst = 1'b1;

  trb_st2bus_if #(.ST(ST), .BUS_W(BUS_W), .CNT_W(CNT_W)) io ();

`ifdef TRB_ST2BUS_STAT_EN
  logic [15:0] pkt_cnt;
  logic [15:0] drop_cnt;
`endif

  trb_st2bus #(.ST(ST), .BUS_W(BUS_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
`ifdef TRB_ST2BUS_STAT_EN
    ,
    .pkt_cnt  (pkt_cnt),
    .drop_cnt (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [BUS_W-1:0] data;
    logic [CNT_W-1:0] bytes;
    logic             last;
  } word_t;

  word_t            exp_q[$];
  byte unsigned     cur[$];
  bit               m_in_pkt;
  int               m_drop;
  int               m_pkt;
  int               checks;
  int               failures;
  int               words_seen;
  int               wait_total;
  int               n_acc;
  bit               rnd_done;
  bit               prev_hold;
  logic [BUS_W-1:0] prev_data;
  logic [CNT_W-1:0] prev_bytes;
  logic             prev_last;

  task automatic chk(input string tag, input logic [BUS_W-1:0] obs, input logic [BUS_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic emit(input bit last);
    word_t w;
    w.data = '0;
    foreach (cur[i]) w.data[i*ST +: ST] = cur[i];
    w.bytes = CNT_W'(cur.size());
    w.last  = last;
    exp_q.push_back(w);
    cur.delete();
  endtask

  // Reference: a packet is a list of beats, cut into BPW-beat words; stray beats are dropped.
  task automatic model_accept(input logic [7:0] d, input bit s, input bit e);
    if (!m_in_pkt && !s) begin
      m_drop++;
      return;
    end
    if (s) begin
      if (m_in_pkt && cur.size() > 0) begin
        emit(1'b1);
        m_drop++;
      end
      cur.delete();
      m_in_pkt = 1'b1;
    end
    cur.push_back(d);
    if (e || cur.size() == BPW) begin
      emit(e);
      m_in_pkt = !e;
    end
  endtask

  task automatic send(input logic [7:0] d, input bit s, input bit e);
    int guard;
    guard = 0;
    io.st_data  = d;
    io.st_sop   = s;
    io.st_eop   = e;
    io.st_valid = 1'b1;
    @(negedge clk);
    while (!io.st_ready && guard < LIMIT) begin
      @(negedge clk);
      guard++;
    end
    wait_total += guard;
    checks++;
    assert (guard < LIMIT) else begin
      failures++;
      $error("FAIL send_timeout observed=%0d expected<%0d", guard, LIMIT);
    end
    @(posedge clk);
    #1;
    if (guard < LIMIT) begin
      model_accept(d, s, e);
      n_acc++;
    end
    io.st_valid = 1'b0;
  endtask

  task automatic send_pkt(input int n, input bit rnd, input bit with_eop);
    for (int i = 0; i < n; i++)
      send(rnd ? 8'($urandom) : 8'(i), i == 0, with_eop && (i == n - 1));
  endtask

  task automatic wait_drain();
    for (int g = 0; g < LIMIT && exp_q.size() != 0; g++) @(negedge clk);
    chk("drain_empty", exp_q.size(), 0);
    repeat (2) @(negedge clk);
`ifdef TRB_ST2BUS_STAT_EN
    chk("stat_pkt_cnt", pkt_cnt, m_pkt);
    chk("stat_drop_cnt", drop_cnt, m_drop);
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    word_t w;
    forever begin
      @(negedge clk);
      if (prev_hold && !rst) begin
        chk("hold_valid", io.bus_valid, 1'b1);
        chk("hold_data", io.bus_data, prev_data);
        chk("hold_bytes", io.bus_bytes, prev_bytes);
        chk("hold_last", io.bus_last, prev_last);
      end
      prev_hold  = io.bus_valid && !io.bus_ready && !rst;
      prev_data  = io.bus_data;
      prev_bytes = io.bus_bytes;
      prev_last  = io.bus_last;
      if (io.bus_valid && io.bus_ready) begin
        checks++;
        assert (exp_q.size() > 0) else begin
          failures++;
          $error("FAIL unexpected_word observed_bytes=%0d expected=no_word", io.bus_bytes);
        end
        if (exp_q.size() > 0) begin
          w = exp_q.pop_front();
          chk("word_data", io.bus_data, w.data);
          chk("word_bytes", io.bus_bytes, w.bytes);
          chk("word_last", io.bus_last, w.last);
          if (w.last) m_pkt++;
        end
        words_seen++;
      end
    end
  endtask

  initial begin
    int ws;
    io.st_data   = '0;
    io.st_valid  = 1'b0;
    io.st_sop    = 1'b0;
    io.st_eop    = 1'b0;
    io.bus_ready = 1'b1;
    fork
      monitor();
    join_none

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_st_ready", io.st_ready, 1'b0);
    chk("rst_bus_valid", io.bus_valid, 1'b0);
    chk("rst_bus_data", io.bus_data, '0);
    chk("rst_bus_bytes", io.bus_bytes, '0);
    chk("rst_bus_last", io.bus_last, 1'b0);
    rst = 1'b0;
    #1;
    chk("post_rst_st_ready", io.st_ready, 1'b1);
    @(posedge clk);
    #1;

    // 128-beat incrementing packet, latency and no-bubble checks
    wait_total = 0;
    for (int i = 0; i < 128; i++) begin
      send(8'(i), i == 0, i == 127);
      if (i == 62) chk("word0_not_early", io.bus_valid, 1'b0);
      if (i == 63) chk("word0_latency", io.bus_valid, 1'b1);
    end
    chk("no_bubbles", wait_total, 0);
    wait_drain();

    // 70-beat packet: short zero-padded second word
    send_pkt(70, 1'b1, 1'b1);
    wait_drain();

    // Backpressure: 256-beat packet with the bus stalled for 200 cycles
    n_acc = 0;
    ws    = words_seen;
    fork
      begin
        io.bus_ready = 1'b0;
        repeat (200) @(posedge clk);
        #1;
        io.bus_ready = 1'b1;
      end
      send_pkt(256, 1'b1, 1'b1);
      begin
        repeat (180) @(negedge clk);
        chk("stall_accepted", n_acc, 128);
        chk("stall_st_ready", io.st_ready, 1'b0);
        chk("stall_no_words", words_seen - ws, 0);
      end
    join
    wait_drain();
    chk("stall_words", words_seen - ws, 4);

    // Stray beats then a single-beat packet
    for (int i = 0; i < 5; i++) send(8'($urandom), 1'b0, 1'($urandom));
    send(8'hA5, 1'b1, 1'b1);
    wait_drain();

    // Truncation by sop at beat 10
    send_pkt(10, 1'b1, 1'b0);
    send_pkt(20, 1'b1, 1'b1);
    wait_drain();

    // Truncation while the output buffer is busy (side beat path), plus sop+eop truncation
    fork
      begin
        io.bus_ready = 1'b0;
        repeat (150) @(posedge clk);
        #1;
        io.bus_ready = 1'b1;
      end
      begin
        send_pkt(69, 1'b1, 1'b0);
        send(8'h3C, 1'b1, 1'b0);
        send(8'h5A, 1'b0, 1'b0);
        send(8'h77, 1'b1, 1'b1);
      end
    join
    wait_drain();

    // Randomized packets under random bus backpressure
    rnd_done = 1'b0;
    fork
      begin
        for (int p = 0; p < 30; p++) begin
          int n;
          if ($urandom_range(0, 3) == 0)
            for (int s = 0; s < $urandom_range(1, 3); s++) send(8'($urandom), 1'b0, 1'($urandom));
          n = $urandom_range(1, 140);
          send_pkt(n, 1'b1, $urandom_range(0, 4) != 0);
        end
        send(8'h11, 1'b1, 1'b1);
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          io.bus_ready = ($urandom_range(0, 2) != 0);
        end
        io.bus_ready = 1'b1;
      end
    join
    wait_drain();

    // Reset in the middle of a packet
    for (int i = 0; i < 30; i++) send(8'($urandom), i == 0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_st_ready", io.st_ready, 1'b0);
    chk("midrst_bus_valid", io.bus_valid, 1'b0);
    chk("midrst_bus_data", io.bus_data, '0);
    chk("midrst_bus_bytes", io.bus_bytes, '0);
    chk("midrst_bus_last", io.bus_last, 1'b0);
    cur.delete();
    m_in_pkt = 1'b0;
    m_drop   = 0;
    m_pkt    = 0;
    repeat (3) @(negedge clk);
`ifdef TRB_ST2BUS_STAT_EN
    chk("midrst_pkt_cnt", pkt_cnt, 0);
    chk("midrst_drop_cnt", drop_cnt, 0);
`endif
    rst = 1'b0;
    @(posedge clk);
    #1;
    ws = words_seen;
    send_pkt(128, 1'b1, 1'b1);
    wait_drain();
    chk("post_rst_words", words_seen - ws, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
